// File: rtl/prog_counter_pkg.sv
// Shared types for the program counter: FSM states and next-pc operation codes.
package prog_counter_pkg;

    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_HALT = 1'b1
    } pc_state_t;

    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_INC    = 3'd1,
        OP_JUMP   = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_BRANCH = 3'd5
    } pc_op_t;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack for prog_counter, kept as a shift register with the top at entry 0.
module pc_ras #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, full_q;
    logic          do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q && !push;

    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + CW'(1);
        end else if (do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[0] <= din;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    mem_q[i] <= mem_q[i-1];
                end
            end else if (do_pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    mem_q[i] <= mem_q[i+1];
                end
                mem_q[DEPTH-1] <= '0;
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    assign dout  = mem_q[0];
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/prog_counter.sv
// Program counter with step/free-run advance, jump/call/ret/branch and RUN/HALT control.
// Define PROG_COUNTER_RAS_EN to build the return-address stack; otherwise call acts as jump.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned LAST_ADDR = 2**PC_W - 1,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic            step,
    input  logic            jump,
    input  logic            call,
    input  logic            ret,
    input  logic            branch,
    input  logic [PC_W-1:0] target,
    input  logic [PC_W-1:0] offset,
    input  logic            halt_req,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            wrap,
    output logic            err,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam logic [PC_W-1:0] LAST = PC_W'(LAST_ADDR);

`ifdef PROG_COUNTER_RAS_EN
    localparam pc_op_t CALL_OP = OP_CALL;
    localparam pc_op_t RET_OP  = OP_RET;
`else
    localparam pc_op_t CALL_OP = OP_JUMP;
    localparam pc_op_t RET_OP  = OP_INC;
`endif

    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            wrap_q, wrap_d;
    logic            err_q, err_d;

    logic            advance;
    pc_op_t          op;
    logic            at_last;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_sum;
    logic            target_ok;
    logic            sum_ok;

    logic            ras_push, ras_pop;
    logic [PC_W-1:0] stk_dout;
    logic            stk_empty, stk_full;

    assign at_last = (pc_q == LAST);
    assign pc_inc  = at_last ? '0 : pc_q + PC_W'(1);
    assign br_sum  = pc_q + offset;

    // With a full-range address map every PC_W-bit value is legal.
    if (LAST_ADDR >= 2**PC_W - 1) begin : g_full_range
        assign target_ok = 1'b1;
        assign sum_ok    = 1'b1;
    end else begin : g_part_range
        assign target_ok = (target <= LAST);
        assign sum_ok    = (br_sum <= LAST);
    end

    assign advance = (state_q == PC_RUN) && !halt_req && (mode || step);

    always_comb begin
        op = OP_HOLD;
        if (advance) begin
            if (jump) begin
                op = OP_JUMP;
            end else if (call) begin
                op = CALL_OP;
            end else if (ret) begin
                op = RET_OP;
            end else if (branch) begin
                op = OP_BRANCH;
            end else begin
                op = OP_INC;
            end
        end
    end

    always_comb begin
        pc_d     = pc_q;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        case (op)
            OP_INC: begin
                pc_d   = pc_inc;
                wrap_d = at_last;
            end
            OP_JUMP: begin
                if (target_ok) begin
                    pc_d = target;
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_CALL: begin
                if (!target_ok) begin
                    err_d = 1'b1;
                end else begin
                    pc_d = target;
                    // A full stack still takes the call but loses the return address.
                    if (stk_full) begin
                        err_d = 1'b1;
                    end else begin
                        ras_push = 1'b1;
                    end
                end
            end
            OP_RET: begin
                if (stk_empty) begin
                    pc_d   = pc_inc;
                    wrap_d = at_last;
                    err_d  = 1'b1;
                end else begin
                    pc_d    = stk_dout;
                    ras_pop = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (sum_ok) begin
                    pc_d = br_sum;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PC_RUN: begin
                if (halt_req) begin
                    state_d = PC_HALT;
                end
            end
            PC_HALT: begin
                if (resume && !halt_req) begin
                    state_d = PC_RUN;
                end
            end
            default: state_d = PC_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PC_RUN;
            pc_q    <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

`ifdef PROG_COUNTER_RAS_EN
    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .empty (stk_empty),
        .full  (stk_full)
    );

    assign ras_empty = stk_empty;
    assign ras_full  = stk_full;
`else
    logic unused_ras;

    assign stk_dout   = '0;
    assign stk_empty  = 1'b1;
    assign stk_full   = 1'b0;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign unused_ras = ^{ras_push, ras_pop};
`endif

    assign pc     = pc_q;
    assign halted = (state_q == PC_HALT);
    assign wrap   = wrap_q;
    assign err    = err_q;

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: vector tables, hand sequences and a queue-based model.
module tb_prog_counter;

    localparam int LAST  = 200;
    localparam int DEPTH = 2;

    logic       clk, rst;
    logic       mode, step, jump, call, ret, branch, halt_req, resume;
    logic [7:0] target, offset, pc;
    logic       halted, wrap, err, ras_empty, ras_full;

    logic       mode3, z;
    logic [2:0] z3, pc3;
    logic       halted3, wrap3, err3, empty3, full3;

    typedef struct {
        string      name;
        bit         mode, step, jump, call, ret, branch, halt_req, resume;
        logic [7:0] target, offset;
        int         pc;
        bit         wrap, err, halted, empty, full;
    } vec_t;

    vec_t vecs[$];
    int   n_tests, n_fail;

    int   m_pc;
    bit   m_halted, m_wrap, m_err;
    int   m_stack[$];

    prog_counter #(
        .PC_W      (8),
        .LAST_ADDR (LAST),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .step      (step),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .branch    (branch),
        .target    (target),
        .offset    (offset),
        .halt_req  (halt_req),
        .resume    (resume),
        .pc        (pc),
        .halted    (halted),
        .wrap      (wrap),
        .err       (err),
        .ras_empty (ras_empty),
        .ras_full  (ras_full)
    );

    prog_counter #(
        .PC_W (3)
    ) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode3),
        .step      (z),
        .jump      (z),
        .call      (z),
        .ret       (z),
        .branch    (z),
        .target    (z3),
        .offset    (z3),
        .halt_req  (z),
        .resume    (z),
        .pc        (pc3),
        .halted    (halted3),
        .wrap      (wrap3),
        .err       (err3),
        .ras_empty (empty3),
        .ras_full  (full3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        {mode, step, jump, call, ret, branch, halt_req, resume} = '0;
        target = '0;
        offset = '0;
        mode3  = 1'b0;
    endtask

    task automatic add(input string name, input bit md, st, jp, cl, rt, br, hr, rs,
                       input logic [7:0] tg, of, input int epc,
                       input bit ew, ee, eh, eem, efu);
        vec_t v;
        v.name = name;
        v.mode = md; v.step = st; v.jump = jp; v.call = cl; v.ret = rt; v.branch = br;
        v.halt_req = hr; v.resume = rs; v.target = tg; v.offset = of;
        v.pc = epc; v.wrap = ew; v.err = ee; v.halted = eh; v.empty = eem; v.full = efu;
        vecs.push_back(v);
    endtask

    // Entered #1 after a rising edge; checks reset takes effect before the next edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_pc", int'(pc), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_wrap", int'(wrap), 0);
        check("rst_err", int'(err), 0);
        check("rst_empty", int'(ras_empty), 1);
        check("rst_full", int'(ras_full), 0);
        check("rst_pc3", int'(pc3), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        m_pc = 0;
        m_halted = 1'b0;
        m_stack.delete();
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            mode = vecs[i].mode; step = vecs[i].step; jump = vecs[i].jump;
            call = vecs[i].call; ret = vecs[i].ret; branch = vecs[i].branch;
            halt_req = vecs[i].halt_req; resume = vecs[i].resume;
            target = vecs[i].target; offset = vecs[i].offset;
            @(posedge clk);
            #1;
            check({vecs[i].name, "_pc"}, int'(pc), vecs[i].pc);
            check({vecs[i].name, "_wrap"}, int'(wrap), int'(vecs[i].wrap));
            check({vecs[i].name, "_err"}, int'(err), int'(vecs[i].err));
            check({vecs[i].name, "_halted"}, int'(halted), int'(vecs[i].halted));
            check({vecs[i].name, "_empty"}, int'(ras_empty), int'(vecs[i].empty));
            check({vecs[i].name, "_full"}, int'(ras_full), int'(vecs[i].full));
        end
        vecs.delete();
        clear_inputs();
    endtask

    // Reference: one clock of behaviour derived directly from the rules.
    task automatic model_step();
        int inc, s;
        bit adv;
        inc = (m_pc == LAST) ? 0 : m_pc + 1;
        adv = !m_halted && !halt_req && (mode || step);
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (adv) begin
            if (jump) begin
                if (int'(target) > LAST) m_err = 1'b1;
                else m_pc = int'(target);
            end else if (call) begin
                if (int'(target) > LAST) begin
                    m_err = 1'b1;
                end else begin
`ifdef PROG_COUNTER_RAS_EN
                    if (m_stack.size() == DEPTH) m_err = 1'b1;
                    else m_stack.push_back(inc);
`endif
                    m_pc = int'(target);
                end
            end else if (ret) begin
`ifdef PROG_COUNTER_RAS_EN
                if (m_stack.size() == 0) begin
                    m_err  = 1'b1;
                    m_wrap = (inc == 0);
                    m_pc   = inc;
                end else begin
                    m_pc = m_stack.pop_back();
                end
`else
                m_wrap = (inc == 0);
                m_pc   = inc;
`endif
            end else if (branch) begin
                s = (m_pc + int'(offset)) % 256;
                if (s > LAST) m_err = 1'b1;
                else m_pc = s;
            end else begin
                m_wrap = (inc == 0);
                m_pc   = inc;
            end
        end
        if (m_halted) m_halted = !resume || halt_req;
        else m_halted = halt_req;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        z  = 1'b0;
        z3 = '0;
        rst = 1'b0;
        clear_inputs();
        #1;
        do_reset();

        //    name    md st jp cl rt br hr rs target  offset  pc  w  e  h  em fu
        add("idle0",  0, 0, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,   0,  0, 0, 0, 1, 0);
        add("step1",  0, 1, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,   1,  0, 0, 0, 1, 0);
        add("step2",  0, 1, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,   2,  0, 0, 0, 1, 0);
        add("idle2",  0, 0, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,   2,  0, 0, 0, 1, 0);
        add("step3",  0, 1, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,   3,  0, 0, 0, 1, 0);
        add("step4",  0, 1, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,   4,  0, 0, 0, 1, 0);
        add("step5",  0, 1, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,   5,  0, 0, 0, 1, 0);
        add("brneg",  0, 1, 0, 0, 0, 1, 0, 0, 8'd0,   8'hFE,  3,  0, 0, 0, 1, 0);
        add("jpbr",   0, 1, 1, 0, 0, 1, 0, 0, 8'd9,   8'd1,   9,  0, 0, 0, 1, 0);
        add("jpbad",  0, 1, 1, 0, 0, 0, 0, 0, 8'd201, 8'd0,   9,  0, 1, 0, 1, 0);
        add("step10", 0, 1, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,   10, 0, 0, 0, 1, 0);
        add("brbad",  0, 1, 0, 0, 0, 1, 0, 0, 8'd0,   8'd200, 10, 0, 1, 0, 1, 0);
        add("brto0",  0, 1, 0, 0, 0, 1, 0, 0, 8'd0,   8'hF6,  0,  0, 0, 0, 1, 0);
        add("jplast", 0, 1, 1, 0, 0, 0, 0, 0, 8'd200, 8'd0,   200, 0, 0, 0, 1, 0);
        add("wrap",   0, 1, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,   0,  1, 0, 0, 1, 0);
        add("nostjp", 0, 0, 1, 0, 0, 0, 0, 0, 8'd50,  8'd0,   0,  0, 0, 0, 1, 0);
        add("jp3",    0, 1, 1, 0, 0, 0, 0, 0, 8'd3,   8'd0,   3,  0, 0, 0, 1, 0);
        add("step4b", 0, 1, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,   4,  0, 0, 0, 1, 0);
        add("halt",   0, 1, 0, 0, 0, 0, 1, 0, 8'd0,   8'd0,   4,  0, 0, 1, 1, 0);
        add("hstep",  0, 1, 1, 0, 0, 0, 0, 0, 8'd50,  8'd0,   4,  0, 0, 1, 1, 0);
        add("hboth",  0, 1, 0, 0, 0, 0, 1, 1, 8'd0,   8'd0,   4,  0, 0, 1, 1, 0);
        add("resume", 0, 1, 0, 0, 0, 0, 0, 1, 8'd0,   8'd0,   4,  0, 0, 0, 1, 0);
        add("step5b", 0, 1, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,   5,  0, 0, 0, 1, 0);
        add("run6",   1, 0, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,   6,  0, 0, 0, 1, 0);
        add("run7",   1, 0, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,   7,  0, 0, 0, 1, 0);
        add("runhlt", 1, 0, 0, 0, 0, 0, 1, 0, 8'd0,   8'd0,   7,  0, 0, 1, 1, 0);
        run_vecs();
        do_reset();

`ifdef PROG_COUNTER_RAS_EN
        add("c_step", 0, 1, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,   1,  0, 0, 0, 1, 0);
        add("c_10",   0, 1, 0, 1, 0, 0, 0, 0, 8'd10,  8'd0,   10, 0, 0, 0, 0, 0);
        add("c_20",   0, 1, 0, 1, 0, 0, 0, 0, 8'd20,  8'd0,   20, 0, 0, 0, 0, 1);
        add("c_30",   0, 1, 0, 1, 0, 0, 0, 0, 8'd30,  8'd0,   30, 0, 1, 0, 0, 1);
        add("r_1",    0, 1, 0, 0, 1, 0, 0, 0, 8'd0,   8'd0,   11, 0, 0, 0, 0, 0);
        add("r_2",    0, 1, 0, 0, 1, 0, 0, 0, 8'd0,   8'd0,   2,  0, 0, 0, 1, 0);
        add("r_empty", 0, 1, 0, 0, 1, 0, 0, 0, 8'd0,  8'd0,   3,  0, 1, 0, 1, 0);
        add("c_bad",  0, 1, 0, 1, 0, 0, 0, 0, 8'd250, 8'd0,   3,  0, 1, 0, 1, 0);
        add("c_ok",   0, 1, 0, 1, 0, 0, 0, 0, 8'd40,  8'd0,   40, 0, 0, 0, 0, 0);
`else
        add("c_step", 0, 1, 0, 0, 0, 0, 0, 0, 8'd0,   8'd0,   1,  0, 0, 0, 1, 0);
        add("c_10",   0, 1, 0, 1, 0, 0, 0, 0, 8'd10,  8'd0,   10, 0, 0, 0, 1, 0);
        add("c_20",   0, 1, 0, 1, 0, 0, 0, 0, 8'd20,  8'd0,   20, 0, 0, 0, 1, 0);
        add("c_30",   0, 1, 0, 1, 0, 0, 0, 0, 8'd30,  8'd0,   30, 0, 0, 0, 1, 0);
        add("r_1",    0, 1, 0, 0, 1, 0, 0, 0, 8'd0,   8'd0,   31, 0, 0, 0, 1, 0);
        add("r_2",    0, 1, 0, 0, 1, 0, 0, 0, 8'd0,   8'd0,   32, 0, 0, 0, 1, 0);
        add("r_empty", 0, 1, 0, 0, 1, 0, 0, 0, 8'd0,  8'd0,   33, 0, 0, 0, 1, 0);
        add("c_bad",  0, 1, 0, 1, 0, 0, 0, 0, 8'd250, 8'd0,   33, 0, 1, 0, 1, 0);
        add("c_ok",   0, 1, 0, 1, 0, 0, 0, 0, 8'd40,  8'd0,   40, 0, 0, 0, 1, 0);
`endif
        run_vecs();
        do_reset();

        // Narrow instance free-running through its full 3-bit range.
        mode3 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            check("w3_pc", int'(pc3), (i + 1) % 8);
            check("w3_wrap", int'(wrap3), (i == 7) ? 1 : 0);
        end
        mode3 = 1'b0;
        @(posedge clk);
        #1;
        check("w3_hold", int'(pc3), 1);
        check("w3_wrap_low", int'(wrap3), 0);
        check("w3_err", int'(err3), 0);
        check("w3_halted", int'(halted3), 0);
        check("w3_empty", int'(empty3), 1);
        check("w3_full", int'(full3), 0);

        do_reset();
        for (int n = 0; n < 600; n++) begin
            mode     = ($urandom_range(3) == 0);
            step     = ($urandom_range(1) == 0);
            jump     = ($urandom_range(5) == 0);
            call     = ($urandom_range(3) == 0);
            ret      = ($urandom_range(3) == 0);
            branch   = ($urandom_range(3) == 0);
            halt_req = ($urandom_range(15) == 0);
            resume   = ($urandom_range(3) == 0);
            target   = 8'($urandom_range(255));
            offset   = 8'($urandom_range(255));
            model_step();
            @(posedge clk);
            #1;
            check("rnd_pc", int'(pc), m_pc);
            check("rnd_wrap", int'(wrap), int'(m_wrap));
            check("rnd_err", int'(err), int'(m_err));
            check("rnd_halted", int'(halted), int'(m_halted));
            check("rnd_empty", int'(ras_empty), (m_stack.size() == 0) ? 1 : 0);
            check("rnd_full", int'(ras_full), (m_stack.size() == DEPTH) ? 1 : 0);
        end

        // Reset mid-stream, likely with a nonzero pc, must still act at once.
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
